// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter among N_REQ byte streams.
// A granted requester keeps the UART until its last byte, or until it idles past HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int N_REQ        = 3,
    parameter int HOLD_TIMEOUT = 65535,
    parameter int TO_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     start,
    output logic [7:0]               din_tx,
    input  logic                     done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int GW = $clog2(N_REQ);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(HOLD_TIMEOUT - 1);
    localparam logic [GW-1:0]    LAST_IDX = GW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_HOLD} state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     grant_id_reg, grant_id_next;
    logic [GW-1:0]     last_grant_reg, last_grant_next;
    logic              busy_reg, busy_next;
    logic [N_REQ-1:0]  req_ready_reg, req_ready_next;
    logic              start_reg, start_next;
    logic [7:0]        din_tx_reg, din_tx_next;
    logic              last_flag_reg, last_flag_next;
    logic              timeout_err_reg, timeout_err_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;

    logic [7:0]        req_bytes [N_REQ];
    logic [GW-1:0]     pick_id;
    logic [GW-1:0]     scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        pick_id  = '0;
        scan_idx = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            scan_idx = GW'((int'(last_grant_reg) + off) % N_REQ);
            if (req_valid[scan_idx]) begin
                pick_id = scan_idx;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_id_next    = grant_id_reg;
        last_grant_next  = last_grant_reg;
        busy_next        = busy_reg;
        req_ready_next   = '0;
        start_next       = 1'b0;
        din_tx_next      = din_tx_reg;
        last_flag_next   = last_flag_reg;
        timeout_err_next = 1'b0;
        to_cnt_next      = to_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_id_next  = pick_id;
                    busy_next      = 1'b1;
                    req_ready_next = ONE_HOT0 << pick_id;
                    state_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                din_tx_next    = req_bytes[grant_id_reg];
                last_flag_next = req_last[grant_id_reg];
                start_next     = 1'b1;
                state_next     = S_START;
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    if (last_flag_reg) begin
                        last_grant_next = grant_id_reg;
                        busy_next       = 1'b0;
                        state_next      = S_IDLE;
                    end else begin
                        to_cnt_next = '0;
                        state_next  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (req_valid[grant_id_reg]) begin
                    req_ready_next = ONE_HOT0 << grant_id_reg;
                    state_next     = S_LOAD;
                end else if (to_cnt_reg == TO_LAST) begin
                    timeout_err_next = 1'b1;
                    last_grant_next  = grant_id_reg;
                    busy_next        = 1'b0;
                    state_next       = S_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            grant_id_reg    <= '0;
            last_grant_reg  <= LAST_IDX;
            busy_reg        <= 1'b0;
            req_ready_reg   <= '0;
            start_reg       <= 1'b0;
            din_tx_reg      <= '0;
            last_flag_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            to_cnt_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            grant_id_reg    <= grant_id_next;
            last_grant_reg  <= last_grant_next;
            busy_reg        <= busy_next;
            req_ready_reg   <= req_ready_next;
            start_reg       <= start_next;
            din_tx_reg      <= din_tx_next;
            last_flag_reg   <= last_flag_next;
            timeout_err_reg <= timeout_err_next;
            to_cnt_reg      <= to_cnt_next;
        end
    end

    assign req_ready   = req_ready_reg;
    assign start       = start_reg;
    assign din_tx      = din_tx_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a small requester queue model feeds bytes, the bench plays uart_top's done.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        start;
    logic [7:0]  din_tx;
    logic        done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] q_data [3][8];
    logic       q_last [3][8];
    int         q_len  [3];
    int         q_ptr  [3];
    logic [7:0] hello  [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    uart_tx_arbiter #(.N_REQ(3), .HOLD_TIMEOUT(20), .TO_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .start(start), .din_tx(din_tx),
        .done(done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_req();
        for (int i = 0; i < 3; i++) begin
            if (q_ptr[i] < q_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q_data[i][q_ptr[i]];
                req_last[i]        = q_last[i][q_ptr[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        q_data[r][q_len[r]] = d;
        q_last[r][q_len[r]] = l;
        q_len[r]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 3; i++) begin
            q_len[i] = 0;
            q_ptr[i] = 0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_start"}, 32'(start), 32'h0);
        chk({tag, "_din_tx"}, 32'(din_tx), 32'h0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    // Waits for the grant's LOAD cycle, checks it, then checks the START cycle and advances the queues.
    task automatic accept_byte(input int exp_id, input logic [7:0] exp_byte);
        int n;
        logic [2:0] acc;
        n = 0;
        while (req_ready == 3'b000 && n < 100) begin
            step();
            n++;
        end
        if (req_ready == 3'b000) begin
            checks++;
            failures++;
            $display("FAIL wait_ready observed=none expected=req%0d", exp_id);
            return;
        end
        chk("req_ready_onehot", 32'(req_ready), 32'(1 << exp_id));
        chk("grant_id_load", 32'(grant_id), 32'(exp_id));
        chk("busy_load", 32'(busy), 32'h1);
        acc = req_ready;
        step();
        chk("start_pulse", 32'(start), 32'h1);
        chk("din_tx_at_start", 32'(din_tx), 32'(exp_byte));
        chk("req_ready_single", 32'(req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) q_ptr[i]++;
        end
        apply_req();
    endtask

    // From the START cycle: enter WAIT, then drive done in the dly-th WAIT cycle.
    task automatic finish_byte(input int dly);
        step();
        chk("start_once", 32'(start), 32'h0);
        repeat (dly - 1) step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        done      = 1'b0;
        clear_q();
        repeat (3) step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Single byte from requester 1
        push(1, 8'h48, 1'b1);
        apply_req();
        accept_byte(1, 8'h48);
        finish_byte(3);
        chk("t1_busy_after_done", 32'(busy), 32'h0);
        chk("t1_grant_kept", 32'(grant_id), 32'h1);
        repeat (3) step();
        chk("t1_no_extra_ready", 32'(req_ready), 32'h0);

        // HELLO from requester 0 while requester 2 waits
        for (int k = 0; k < 5; k++) push(0, hello[k], k == 4);
        apply_req();
        step();
        push(2, 8'h5A, 1'b1);
        apply_req();
        for (int k = 0; k < 5; k++) begin
            accept_byte(0, hello[k]);
            finish_byte(4);
        end
        chk("t2_bubble_ready", 32'(req_ready), 32'h0);
        chk("t2_busy_low", 32'(busy), 32'h0);
        step();
        chk("t2_req2_at_done_plus2", 32'(req_ready), 32'h4);
        accept_byte(2, 8'h5A);
        finish_byte(2);

        // Three continuous requesters, round robin 0,1,2,0,1,2
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 2; k++) push(r, 8'(8'h10 * (r + 1) + k), 1'b1);
        end
        apply_req();
        for (int p = 0; p < 6; p++) begin
            accept_byte(p % 3, 8'(8'h10 * (p % 3 + 1) + p / 3));
            finish_byte(10);
        end
        chk("t3_all_drained", 32'(req_valid), 32'h0);

        // Hold timeout with a done injected during HOLD
        push(1, 8'h41, 1'b0);
        push(2, 8'h42, 1'b1);
        apply_req();
        accept_byte(1, 8'h41);
        finish_byte(3);
        chk("t4_hold_busy", 32'(busy), 32'h1);
        chk("t4_hold_no_err", 32'(timeout_err), 32'h0);
        repeat (4) step();
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (14) step();
        chk("t4_err_not_early", 32'(timeout_err), 32'h0);
        chk("t4_hold_no_start", 32'(start), 32'h0);
        chk("t4_hold_ignores_req2", 32'(req_ready), 32'h0);
        step();
        chk("t4_timeout_err", 32'(timeout_err), 32'h1);
        chk("t4_busy_fell", 32'(busy), 32'h0);
        chk("t4_grant_kept", 32'(grant_id), 32'h1);
        step();
        chk("t4_err_one_cycle", 32'(timeout_err), 32'h0);
        chk("t4_req2_next", 32'(req_ready), 32'h4);
        accept_byte(2, 8'h42);
        finish_byte(3);

        // Done in IDLE is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("idle_done_no_start", 32'(start), 32'h0);
        chk("idle_done_no_busy", 32'(busy), 32'h0);

        // Reset while in WAIT mid-packet
        push(0, 8'h66, 1'b1);
        apply_req();
        accept_byte(0, 8'h66);
        finish_byte(2);
        push(1, 8'h21, 1'b0);
        push(1, 8'h22, 1'b1);
        apply_req();
        accept_byte(1, 8'h21);
        step();
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        clear_q();
        apply_req();
        step();
        reset = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("stray_done_busy", 32'(busy), 32'h0);
        chk("stray_done_start", 32'(start), 32'h0);
        step();
        chk("stray_done_no_ready", 32'(req_ready), 32'h0);
        push(0, 8'h77, 1'b1);
        push(1, 8'h88, 1'b1);
        apply_req();
        accept_byte(0, 8'h77);
        finish_byte(2);
        accept_byte(1, 8'h88);
        finish_byte(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single 8-bit UART transmitter in uart_top between N_REQ independent byte-stream requesters, such as telemetry, debug echo and PID status.
- Arbitration is round-robin at packet granularity. A granted requester keeps the transmitter until it delivers a byte flagged last, or until it stalls past a timeout.
- The block sequences uart_top's start/din_tx/done handshake, so requesters never touch the UART directly.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- HOLD_TIMEOUT, 65535, max clk cycles a granted requester may leave req_valid low between bytes of a packet before the grant is revoked
- TO_W, 16, width of the timeout counter; must satisfy HOLD_TIMEOUT < 2^TO_W

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  bit i: requester i offers a byte
- req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i]
- req_last  input  N_REQ  bit i: the offered byte ends requester i's packet
- req_ready  output  N_REQ  one-hot, 1-cycle pulse; byte of requester i is accepted this cycle
- start  output  1  1-cycle pulse to uart_top start
- din_tx  output  8  byte to uart_top, held stable from start until done
- done  input  1  1-cycle pulse from uart_top when the byte is fully shifted out
- grant_id  output  $clog2(N_REQ)  index of the current owner; valid while busy=1
- busy  output  1  a packet is in progress
- timeout_err  output  1  1-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; req_ready=0, start=0, din_tx=0, grant_id=0, busy=0, timeout_err=0.
- Reset also clears last_grant to N_REQ-1, so requester 0 has first priority.
- Reset mid-byte aborts the packet. uart_top's own byte completion is then ignored.
- Requester rule: once req_valid[i]=1, req_valid, req_data and req_last of requester i stay stable until req_ready[i] pulses.
- All outputs are registered.
- FSM: IDLE -> LOAD -> START -> WAIT -> (IDLE | HOLD); HOLD -> (LOAD | IDLE).
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from last_grant+1, modulo N_REQ.
  - Register the pick in grant_id, set busy=1, go to LOAD.
  - No valid bits: stay in IDLE.
- LOAD (1 cycle):
  - req_ready[grant_id]=1.
  - din_tx <= req_data[grant_id]; last_flag <= req_last[grant_id].
  - Go to START.
- START (1 cycle): start=1, go to WAIT.
- WAIT:
  - Stay until done=1. done seen in any other state is ignored.
  - On done with last_flag=1: go to IDLE, last_grant <= grant_id, busy <= 0.
  - On done with last_flag=0: go to HOLD, clear the timeout counter.
- HOLD:
  - Only requester grant_id is considered. Other requests wait, even if asserted.
  - If req_valid[grant_id]=1: go to LOAD.
  - Otherwise increment the counter. When it reaches HOLD_TIMEOUT: timeout_err=1 for 1 cycle, last_grant <= grant_id, busy <= 0, go to IDLE.
- Rearbitration: takes 1 cycle in IDLE after the packet ends, so back-to-back packets have a minimum 1-cycle bubble between the done pulse and the next req_ready.
- Per-byte overhead: LOAD+START gives 2 cycles from the accepting edge to start; the next req_ready in the same packet comes ≥2 cycles after done.
- Single requester: the same requester may win again immediately after its packet ends, even though its last_grant was just updated.
- Simultaneous events:
  - A request appearing in the same cycle a packet ends is seen in the next IDLE cycle.
  - req_valid dropping while in LOAD is a protocol violation; the byte is still consumed.
- din_tx holds its last value between bytes. grant_id keeps its last value while busy=0.

Test Plan:
- Only req 1 sends 1 byte 0x48 with last=1:
  - req_ready[1] pulses once; start pulses once with din_tx=0x48.
  - After a modelled done: busy=0, grant_id=1.
- Req 0 sends the 5-byte packet "HELLO" (0x48,0x45,0x4C,0x4C,0x4F) while req 2 asserts valid from cycle 1:
  - All 5 bytes go out in order before any req_ready[2].
  - Req 2's byte is accepted exactly 2 cycles after the final done (IDLE, LOAD).
- Req 0, 1 and 2 all valid continuously with 1-byte packets, done 10 cycles after each start:
  - Grant sequence after reset is 0,1,2,0,1,2.
  - No requester starves.
- Req 1 sends byte 0x41 with last=0, then drops valid, HOLD_TIMEOUT=20:
  - timeout_err pulses 20 cycles after HOLD entry; busy falls.
  - Req 2's pending request is granted next.
- Assert reset while in WAIT mid-packet:
  - All outputs return to reset values asynchronously.
  - The subsequent stray done is ignored.
  - The next grant goes to the lowest-index valid requester.
- A done pulse injected in IDLE or HOLD -> no state change, no start.
